// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared constants and types for the RV32M multiply/divide unit.
//   - funct3 encodings MUL..REMU
//   - FSM state encoding (IDLE, CALC, DONE)
//   - XLEN and the special-case result constants
package muldiv_pkg;

  localparam int XLEN = 32;

  // funct3 encodings of the M extension
  localparam logic [2:0] MUL    = 3'd0;
  localparam logic [2:0] MULH   = 3'd1;
  localparam logic [2:0] MULHSU = 3'd2;
  localparam logic [2:0] MULHU  = 3'd3;
  localparam logic [2:0] DIV    = 3'd4;
  localparam logic [2:0] DIVU   = 3'd5;
  localparam logic [2:0] REM    = 3'd6;
  localparam logic [2:0] REMU   = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Quotient returned for a divide by zero, and the most negative integer
  localparam logic [XLEN-1:0] DIV0_QUOT = 32'hFFFF_FFFF;
  localparam logic [XLEN-1:0] INT_MIN   = 32'h8000_0000;

endpackage

// File: rtl/muldiv_if.sv
// muldiv_if: request/response bundle between the operand-read stage and the
// multiply/divide unit, plus the register-bank write port it drives.
//   master: pipeline side (drives req_valid, funct3, rs1/rs2_data, rd_addr, flush)
//   slave : muldiv_unit side (drives req_ready, resp_valid, resp_data, resp_rd, resp_wr)
interface muldiv_if #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
);

  logic              req_valid;
  logic              req_ready;
  logic [2:0]        funct3;
  logic [XLEN-1:0]   rs1_data;
  logic [XLEN-1:0]   rs2_data;
  logic [REG_AW-1:0] rd_addr;
  logic              flush;
  logic              resp_valid;
  logic [XLEN-1:0]   resp_data;
  logic [REG_AW-1:0] resp_rd;
  logic              resp_wr;

  modport master (
    output req_valid, funct3, rs1_data, rs2_data, rd_addr, flush,
    input  req_ready, resp_valid, resp_data, resp_rd, resp_wr
  );

  modport slave (
    input  req_valid, funct3, rs1_data, rs2_data, rd_addr, flush,
    output req_ready, resp_valid, resp_data, resp_rd, resp_wr
  );

endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide execution unit.
// Accepts one operation while idle, iterates one bit per cycle for 32 cycles
// (shift-add multiply or restoring divide on operand magnitudes), applies the
// result sign and presents a one-cycle register-bank write.
// Ports:
//   clk, reset  clock and synchronous active-high reset
//   bus         muldiv_if.slave: request (req_valid/req_ready, funct3,
//               rs1_data, rs2_data, rd_addr, flush) and response
//               (resp_valid, resp_data, resp_rd, resp_wr)
module muldiv_unit #(
  parameter int XLEN   = 32,   // only 32 is supported
  parameter int REG_AW = 5
) (
  input  logic    clk,
  input  logic    reset,
  muldiv_if.slave bus
);

  import muldiv_pkg::*;

  localparam int CW = $clog2(XLEN);

  state_t              state_reg;
  logic [CW-1:0]       count_reg;
  logic [2:0]          op_reg;
  logic [REG_AW-1:0]   rd_reg;
  logic                neg_q_reg;     // negate product / quotient
  logic                neg_r_reg;     // negate remainder
  // Multiply: {partial product, remaining multiplier bits}.
  // Divide:   {partial remainder, dividend bits shifting into quotient}.
  logic [2*XLEN-1:0]   acc_reg;
  logic [XLEN-1:0]     opnd_reg;      // multiplicand or divisor magnitude
  logic [XLEN-1:0]     resp_data_reg;
  logic [REG_AW-1:0]   resp_rd_reg;

  // Accept-cycle decode
  logic                accept;
  logic                a_signed, b_signed, a_neg, b_neg;
  logic [XLEN-1:0]     a_mag, b_mag;
  logic                is_div, div_by_zero, div_ovf, special;
  logic [XLEN-1:0]     special_data;

  // One iteration of the shared datapath
  logic [XLEN:0]       mul_sum;
  logic [2*XLEN-1:0]   mul_step;
  logic [2*XLEN:0]     div_shift;
  logic                div_ge;
  logic [XLEN-1:0]     div_sub;
  logic [2*XLEN-1:0]   div_step;
  logic [2*XLEN-1:0]   acc_step;

  // Sign fix-up of the final iteration's value
  logic [2*XLEN-1:0]   prod;
  logic [XLEN-1:0]     quot, rem;
  logic [XLEN-1:0]     final_data;

  assign accept = (state_reg == IDLE) && bus.req_valid && !bus.flush;

  always_comb begin
    a_signed = 1'b0;
    b_signed = 1'b0;
    case (bus.funct3)
      MUL, MULH, DIV, REM: begin
        a_signed = 1'b1;
        b_signed = 1'b1;
      end
      MULHSU:  a_signed = 1'b1;
      default: ;
    endcase
    a_neg = a_signed && bus.rs1_data[XLEN-1];
    b_neg = b_signed && bus.rs2_data[XLEN-1];
    // Two's-complement absolute value; INT_MIN maps onto itself, which is the
    // correct unsigned magnitude.
    a_mag = a_neg ? -bus.rs1_data : bus.rs1_data;
    b_mag = b_neg ? -bus.rs2_data : bus.rs2_data;

    is_div      = bus.funct3[2];
    div_by_zero = is_div && (bus.rs2_data == '0);
    div_ovf     = ((bus.funct3 == DIV) || (bus.funct3 == REM)) &&
                  (bus.rs1_data == INT_MIN) && (bus.rs2_data == '1);
    special     = div_by_zero || div_ovf;

    // funct3[1] distinguishes REM/REMU from DIV/DIVU
    special_data = '0;
    if (div_by_zero)
      special_data = bus.funct3[1] ? bus.rs1_data : DIV0_QUOT;
    else if (div_ovf)
      special_data = bus.funct3[1] ? '0 : INT_MIN;
  end

  always_comb begin
    // Shift-add: add multiplicand into the upper half when the current
    // multiplier bit (acc bit 0) is set, then shift everything right.
    mul_sum  = {1'b0, acc_reg[2*XLEN-1:XLEN]} +
               (acc_reg[0] ? {1'b0, opnd_reg} : '0);
    mul_step = {mul_sum, acc_reg[XLEN-1:1]};

    // Restoring divide: shift left, try subtracting the divisor from the
    // (XLEN+1)-bit partial remainder, keep the difference if it fits.
    div_shift = {acc_reg, 1'b0};
    div_ge    = div_shift[2*XLEN:XLEN] >= {1'b0, opnd_reg};
    div_sub   = div_shift[2*XLEN-1:XLEN] - opnd_reg;
    div_step  = div_ge ? {div_sub, div_shift[XLEN-1:1], 1'b1}
                       : div_shift[2*XLEN-1:0];

    acc_step = op_reg[2] ? div_step : mul_step;

    prod = neg_q_reg ? -acc_step : acc_step;
    quot = neg_q_reg ? -acc_step[XLEN-1:0] : acc_step[XLEN-1:0];
    rem  = neg_r_reg ? -acc_step[2*XLEN-1:XLEN] : acc_step[2*XLEN-1:XLEN];

    final_data = rem;
    case (op_reg)
      MUL:                final_data = prod[XLEN-1:0];
      MULH, MULHSU, MULHU: final_data = prod[2*XLEN-1:XLEN];
      DIV, DIVU:          final_data = quot;
      default:            final_data = rem;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      count_reg     <= '0;
      op_reg        <= MUL;
      rd_reg        <= '0;
      neg_q_reg     <= 1'b0;
      neg_r_reg     <= 1'b0;
      acc_reg       <= '0;
      opnd_reg      <= '0;
      resp_data_reg <= '0;
      resp_rd_reg   <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            op_reg    <= bus.funct3;
            rd_reg    <= bus.rd_addr;
            neg_q_reg <= a_neg ^ b_neg;
            neg_r_reg <= a_neg;
            count_reg <= '0;
            if (is_div) begin
              acc_reg  <= {{XLEN{1'b0}}, a_mag};
              opnd_reg <= b_mag;
            end else begin
              acc_reg  <= {{XLEN{1'b0}}, b_mag};
              opnd_reg <= a_mag;
            end
            if (special) begin
              resp_data_reg <= special_data;
              resp_rd_reg   <= bus.rd_addr;
              state_reg     <= DONE;
            end else begin
              state_reg     <= CALC;
            end
          end
        end
        CALC: begin
          if (bus.flush) begin
            state_reg <= IDLE;
            count_reg <= '0;
          end else begin
            acc_reg   <= acc_step;
            count_reg <= count_reg + 1'b1;
            if (count_reg == CW'(XLEN - 1)) begin
              resp_data_reg <= final_data;
              resp_rd_reg   <= rd_reg;
              state_reg     <= DONE;
            end
          end
        end
        default: begin
          state_reg <= IDLE;
          count_reg <= '0;
        end
      endcase
    end
  end

  // A flush in the DONE cycle kills that cycle's write.
  assign bus.req_ready  = (state_reg == IDLE);
  assign bus.resp_valid = (state_reg == DONE) && !bus.flush;
  assign bus.resp_data  = resp_data_reg;
  assign bus.resp_rd    = resp_rd_reg;
  assign bus.resp_wr    = bus.resp_valid && (resp_rd_reg != '0);

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: scoreboard bench for muldiv_unit. Each issued request pushes
// its expected write (data, rd, wr, due cycle) to a queue; a negedge monitor
// pops and compares on every resp_valid pulse and checks req_ready while busy.
module tb_muldiv_unit;

  import muldiv_pkg::*;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  muldiv_if #(.XLEN(32), .REG_AW(5)) bus ();

  muldiv_unit #(.XLEN(32), .REG_AW(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    string       tag;
    logic [31:0] data;
    logic [4:0]  rd;
    logic        wr;
    int          due;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a,
                                            input logic [31:0] b);
    longint      sa, sb2, ua, ub;
    logic [63:0] p;
    logic [31:0] r;
    sa  = longint'($signed(a));
    sb2 = longint'($signed(b));
    ua  = longint'({32'd0, a});
    ub  = longint'({32'd0, b});
    r   = '0;
    p   = '0;
    case (f)
      MUL:    begin p = sa * sb2; r = p[31:0];  end
      MULH:   begin p = sa * sb2; r = p[63:32]; end
      MULHSU: begin p = sa * ub;  r = p[63:32]; end
      MULHU:  begin p = ua * ub;  r = p[63:32]; end
      DIV: begin
        if (b == 32'd0) r = 32'hFFFF_FFFF;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h8000_0000;
        else begin p = sa / sb2; r = p[31:0]; end
      end
      DIVU: r = (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      REM: begin
        if (b == 32'd0) r = a;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'd0;
        else begin p = sa % sb2; r = p[31:0]; end
      end
      default: r = (b == 32'd0) ? a : a % b;
    endcase
    return r;
  endfunction

  function automatic int ref_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (f[2] && (b == 32'd0 ||
        ((f == DIV || f == REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)))
      return 1;
    return 33;
  endfunction

  // Monitor: cycle count, busy-ready check, response scoreboard
  always @(negedge clk) begin : monitor
    exp_t e;
    cyc++;
    if (!reset) begin
      if (sb.size() != 0)
        check("ready_busy", {31'd0, bus.req_ready}, 32'd0);
      if (!bus.resp_valid)
        check("wr_idle", {31'd0, bus.resp_wr}, 32'd0);
      if (bus.resp_valid) begin
        if (sb.size() == 0) begin
          check("spurious_resp", {31'd0, bus.resp_valid}, 32'd0);
        end else begin
          e = sb.pop_front();
          $display("resp %-10s data=%h rd=%0d wr=%0d cyc=%0d", e.tag, bus.resp_data,
                   bus.resp_rd, bus.resp_wr, cyc);
          check({e.tag, "_data"}, bus.resp_data, e.data);
          check({e.tag, "_rd"}, {27'd0, bus.resp_rd}, {27'd0, e.rd});
          check({e.tag, "_wr"}, {31'd0, bus.resp_wr}, {31'd0, e.wr});
          check({e.tag, "_cycle"}, cyc, e.due);
        end
      end
    end
  end

  // Drive one request; returns just after the accept edge (cycle N+1).
  task automatic issue(input string tag, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd, input bit track,
                       input logic [31:0] exp, input int lat);
    @(posedge clk);
    #1;
    check({tag, "_ready"}, {31'd0, bus.req_ready}, 32'd1);
    bus.req_valid = 1'b1;
    bus.funct3    = f;
    bus.rs1_data  = a;
    bus.rs2_data  = b;
    bus.rd_addr   = rd;
    @(posedge clk);
    if (track) sb.push_back('{tag, exp, rd, (rd != 5'd0), cyc + lat});
    #1;
    bus.req_valid = 1'b0;
    bus.funct3    = 3'($urandom);
    bus.rs1_data  = $urandom;
    bus.rs2_data  = $urandom;
    bus.rd_addr   = 5'($urandom);
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 60) begin
      @(posedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      check({tag, "_timeout"}, 32'(sb.size()), 32'd0);
      sb.delete();
    end
  endtask

  task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd,
                        input logic [31:0] exp, input int lat);
    issue(tag, f, a, b, rd, 1'b1, exp, lat);
    wait_drain(tag);
  endtask

  initial begin
    logic [2:0]  f;
    logic [31:0] a, b;
    bus.req_valid = 1'b0;
    bus.funct3    = 3'd0;
    bus.rs1_data  = '0;
    bus.rs2_data  = '0;
    bus.rd_addr   = '0;
    bus.flush     = 1'b0;

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check("rst_ready", {31'd0, bus.req_ready}, 32'd1);
    check("rst_valid", {31'd0, bus.resp_valid}, 32'd0);
    check("rst_wr", {31'd0, bus.resp_wr}, 32'd0);
    check("rst_data", bus.resp_data, 32'd0);
    check("rst_rd", {27'd0, bus.resp_rd}, 32'd0);

    // Directed multiply / divide
    run_op("mul",      MUL,    32'd7,          32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, 33);
    run_op("mulh",     MULH,   32'h8000_0000,  32'h8000_0000, 5'd6,  32'h4000_0000, 33);
    run_op("mulhu",    MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd7,  32'hFFFF_FFFE, 33);
    run_op("mulhsu",   MULHSU, 32'hFFFF_FFFF,  32'd2,         5'd8,  32'hFFFF_FFFF, 33);
    run_op("div",      DIV,    32'hFFFF_FFF9,  32'd2,         5'd9,  32'hFFFF_FFFD, 33);
    run_op("rem",      REM,    32'hFFFF_FFF9,  32'd2,         5'd10, 32'hFFFF_FFFF, 33);
    run_op("divu",     DIVU,   32'd100,        32'd7,         5'd11, 32'd14,        33);
    run_op("remu",     REMU,   32'd100,        32'd7,         5'd12, 32'd2,         33);
    // Special divide cases complete in one cycle
    run_op("divu0",    DIVU,   32'h1234,       32'd0,         5'd13, 32'hFFFF_FFFF, 1);
    run_op("rem0",     REM,    32'h1234,       32'd0,         5'd14, 32'h1234,      1);
    run_op("div_ovf",  DIV,    32'h8000_0000,  32'hFFFF_FFFF, 5'd15, 32'h8000_0000, 1);
    run_op("rem_ovf",  REM,    32'h8000_0000,  32'hFFFF_FFFF, 5'd16, 32'd0,         1);
    // x0 destination: pulse without write
    run_op("mul_x0",   MUL,    32'd3,          32'd4,         5'd0,  32'd12,        33);

    // Random operations against the reference model
    for (int i = 0; i < 12; i++) begin
      f = 3'($urandom_range(0, 7));
      a = $urandom;
      b = (i % 4 == 3) ? 32'd0 : $urandom;
      if (i == 5) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      run_op($sformatf("rnd%0d", i), f, a, b, 5'($urandom_range(0, 31)),
             ref_model(f, a, b), ref_lat(f, a, b));
    end

    // Known non-zero result before the abort scenarios
    run_op("remu_pre", REMU, 32'd100, 32'd7, 5'd3, 32'd2, 33);

    // Flush in CALC: no response, idle next cycle, result registers held
    issue("div_flush", DIV, 32'd1000, 32'd7, 5'd9, 1'b0, 32'd0, 0);
    repeat (9) @(posedge clk);
    #1 bus.flush = 1'b1;
    @(posedge clk);
    #1 bus.flush = 1'b0;
    check("flush_ready", {31'd0, bus.req_ready}, 32'd1);
    check("flush_hold_data", bus.resp_data, 32'd2);
    repeat (40) @(posedge clk);
    $display("flush     div dropped, cyc=%0d", cyc);

    // Reset mid-operation: clears result registers too
    issue("div_reset", DIV, 32'd1000, 32'd7, 5'd9, 1'b0, 32'd0, 0);
    repeat (9) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    check("reset_ready", {31'd0, bus.req_ready}, 32'd1);
    check("reset_data", bus.resp_data, 32'd0);
    check("reset_rd", {27'd0, bus.resp_rd}, 32'd0);
    repeat (40) @(posedge clk);
    $display("reset     div dropped, cyc=%0d", cyc);

    run_op("mulhu_post", MULHU, 32'hFFFF_FFFF, 32'd2, 5'd20, 32'd1, 33);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide execution unit.
- Consumes the two operands read from the register bank (rs1/rs2 data) and the destination register address.
- Produces the register-bank write port signals (write data, destination register, write enable) after a fixed multi-cycle latency.
- Sits between operand read and writeback. The pipeline stalls on req_ready low.

Parameters:
- XLEN, 32, operand/result width; only 32 is supported.
- REG_AW, 5, register address width.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  1  operation request.
- req_ready  output  1  unit can accept a request (high only in IDLE).
- funct3  input  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- rs1_data  input  XLEN  operand A (dividend / multiplicand).
- rs2_data  input  XLEN  operand B (divisor / multiplier).
- rd_addr  input  REG_AW  destination register.
- flush  input  1  abort the in-flight operation; no response is produced.
- resp_valid  output  1  one-cycle result pulse.
- resp_data  output  XLEN  result, to register-bank write_data.
- resp_rd  output  REG_AW  to register-bank des_reg.
- resp_wr  output  1  to register-bank write; equals resp_valid and (resp_rd != 0).

Behaviour:
- Reset: state IDLE, req_ready=1, resp_valid=0, resp_wr=0, resp_data=0, resp_rd=0, counter=0.
- States:
  - IDLE → CALC on accept (req_valid && req_ready), normal case.
  - IDLE → DONE on accept, special divide case.
  - CALC → DONE when the iteration counter reaches 31.
  - DONE → IDLE unconditionally.
- On accept, latch funct3, rd_addr, operand magnitudes and result sign. Operands are ignored outside the accept cycle.
- Signedness:
  - MUL, MULH, DIV, REM: both operands signed.
  - MULHSU: rs1 signed, rs2 unsigned.
  - MULHU, DIVU, REMU: both unsigned.
- Magnitude of a signed value = two's-complement absolute value. 0x80000000 yields 0x80000000 unsigned.
- Multiply datapath: unsigned shift-add, one multiplier bit per cycle, 64-bit accumulator, 32 iterations.
  - Negate the 64-bit product when operand signs differ.
  - MUL returns bits [31:0]; MULH, MULHSU, MULHU return bits [63:32].
- Divide datapath: unsigned restoring divide, one quotient bit per cycle, 32 iterations.
  - Quotient is negated when signed and operand signs differ.
  - Remainder takes the sign of the dividend.
- Special divide cases, detected on accept; they skip CALC and go straight to DONE:
  - Divisor == 0: DIV/DIVU return 0xFFFFFFFF; REM/REMU return rs1.
  - Signed overflow (DIV/REM, rs1=0x80000000, rs2=0xFFFFFFFF): DIV returns 0x80000000; REM returns 0.
- Latency, with the accept edge at cycle N:
  - Normal: resp_valid high in cycle N+33.
  - Special: resp_valid high in cycle N+1.
- resp_valid is high only in DONE, for exactly one cycle. resp_data and resp_rd are registered and held until the next DONE.
- rd_addr = 0: resp_valid pulses, resp_wr stays 0, so x0 is never written.
- req_ready is 0 in CALC and DONE. The earliest next accept is the cycle after DONE; there is no back-to-back overlap.
- Flush:
  - In CALC or DONE: go to IDLE next cycle, suppress resp_valid/resp_wr that cycle, clear the counter.
  - Flush during an accept cycle drops that request.
- Reset mid-operation: behaves as flush and also clears resp_data/resp_rd. Reset has priority over flush and accept.

Decomposition:
- Package muldiv_pkg holds:
  - funct3 localparams: MUL..REMU.
  - State encoding: IDLE, CALC, DONE.
  - XLEN constant.
  - Constants DIV0_QUOT=0xFFFFFFFF and INT_MIN=0x80000000.
- Single flat module; multiply and divide share the accumulator, shift register and counter.
- No sub-module is required. The special-case detector stays inline, as combinational logic on the accept cycle.

Test Plan:
- MUL rs1=7, rs2=0xFFFFFFFD (-3), rd=5 → resp_data=0xFFFFFFEB, resp_rd=5, resp_wr=1 at N+33; req_ready low N+1..N+33.
- MULH 0x80000000×0x80000000 → 0x40000000; MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE; MULHSU 0xFFFFFFFF×2 → 0xFFFFFFFF.
- DIV 0xFFFFFFF9 (-7) / 2 → 0xFFFFFFFD; REM same operands → 0xFFFFFFFF; DIVU 100/7 → 14; REMU 100/7 → 2; all at N+33.
- DIVU 0x1234/0 → 0xFFFFFFFF at N+1; REM 0x1234/0 → 0x1234; DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM same operands → 0.
- MUL 3×4 with rd=0 → resp_valid=1, resp_wr=0, resp_data=12.
- DIV accepted at N with flush at N+10 → no resp_valid ever; req_ready=1 at N+11. Repeat with reset instead → resp_data=0, resp_rd=0. Then a new MULHU is accepted and completes correctly.
